// File: rtl/celda_pkg.sv
// Shared constants and the golden A > B reference for the magnitude comparator chain.
package celda_pkg;

  localparam int unsigned CELDA_N_DEFAULT = 3;
  localparam int unsigned CELDA_N_MAX     = 16;

  // Behavioural A > B over the widest legal operand width.
  function automatic logic celda_gt_ref(input logic [CELDA_N_MAX-1:0] a,
                                        input logic [CELDA_N_MAX-1:0] b);
    return (a > b);
  endfunction

endpackage

// File: rtl/celda_bit.sv
// One bit stage of the right-to-left comparator: generate/equal terms folded with the
// propagated flag from the next lower bit.
module celda_bit (
  input  logic a,
  input  logic b,
  input  logic p_prev,
  input  logic first,
  output logic p
);

  logic g;
  logic e;
  logic p_in_eff;

  assign g        = a & ~b;
  assign e        = ~(a ^ b);
  // The LSB stage has no lower neighbour, so its propagated input is forced low.
  assign p_in_eff = first ? 1'b0 : p_prev;
  assign p        = g | (e & p_in_eff);

endmodule

// File: rtl/celda_inicial.sv
// Initial cell of the structural unsigned magnitude comparator: P_in = (A > B).
// Define CELDA_INICIAL_REG_OUT_EN to register P_in (async active-low reset to 0).
module celda_inicial
  import celda_pkg::*;
#(
  parameter int unsigned N = CELDA_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         P_in
);

  // chain[i] feeds stage i; chain[i+1] is that stage's result, so chain[N] is the MSB decision.
  logic [N:0] chain;

  assign chain[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_stage
    celda_bit u_bit (
      .a      (A[i]),
      .b      (B[i]),
      .p_prev (chain[i]),
      .first  (1'(i == 0)),
      .p      (chain[i+1])
    );
  end

`ifdef CELDA_INICIAL_REG_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      P_in <= 1'b0;
    end else begin
      P_in <= chain[N];
    end
  end
`else
  // Combinational build: clock and reset have no internal load.
  logic unused_pins;
  assign unused_pins = clk ^ rst_n;
  assign P_in        = chain[N];
`endif

endmodule

// File: tb/tb_celda_inicial.sv
// Self-checking bench for celda_inicial: reset behaviour, directed vectors and an
// exhaustive sweep, with expected results queued at drive time and popped at sample time.
module tb_celda_inicial;
  import celda_pkg::*;

  localparam int unsigned N = 3;

`ifdef CELDA_INICIAL_REG_OUT_EN
  localparam bit REG_OUT = 1'b1;
`else
  localparam bit REG_OUT = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         exp;
    string        name;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         P_in;

  int tests;
  int fails;
  int ones_cnt;
  int pairs_cnt;
  bit exp_q[$];

  celda_inicial #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .P_in  (P_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: A=%b B=%b P_in=%b expected=%b", name, A, B, act, exp);
    end
  endtask

  task automatic scoreboard_pop(input string name);
    bit exp;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, P_in=%b expected=<none>", name, P_in);
    end else begin
      exp = exp_q.pop_front();
      check(name, P_in, exp);
    end
  endtask

  // Wait until a result for the just-driven operands is observable.
  task automatic settle();
    if (REG_OUT) begin
      @(posedge clk);
      #1;
    end else begin
      #3;
    end
  endtask

  task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b, input logic exp,
                       input string name);
    @(negedge clk);
    A = a;
    B = b;
    exp_q.push_back(exp);
    settle();
    scoreboard_pop(name);
  endtask

  vec_t vecs[8];

  initial begin
    tests    = 0;
    fails    = 0;
    ones_cnt = 0;
    pairs_cnt = 0;

    vecs[0] = '{a: 3'b101, b: 3'b011, exp: 1'b1, name: "msb_decides"};
    vecs[1] = '{a: 3'b010, b: 3'b101, exp: 1'b0, name: "a_less"};
    vecs[2] = '{a: 3'b110, b: 3'b111, exp: 1'b0, name: "lsb_decides_lt"};
    vecs[3] = '{a: 3'b111, b: 3'b110, exp: 1'b1, name: "lsb_decides_gt"};
    vecs[4] = '{a: 3'b101, b: 3'b101, exp: 1'b0, name: "equal"};
    vecs[5] = '{a: 3'b100, b: 3'b011, exp: 1'b1, name: "msb_only"};
    vecs[6] = '{a: 3'b000, b: 3'b111, exp: 1'b0, name: "zero_vs_max"};
    vecs[7] = '{a: 3'b011, b: 3'b001, exp: 1'b1, name: "mid_decides"};

    // Reset held with A > B: registered build must read 0, combinational build ignores reset.
    rst_n = 1'b0;
    A     = 3'd4;
    B     = 3'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", P_in, REG_OUT ? 1'b0 : 1'b1);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset", P_in, 1'b1);

    // Assert reset mid-cycle, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_cycle", P_in, REG_OUT ? 1'b0 : 1'b1);
    #1;
    check("async_reset_held", P_in, REG_OUT ? 1'b0 : 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
    end

    // Exhaustive sweep of every unequal pair, one pair per clock period.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        if (a != b) begin
          apply(3'(a), 3'(b), celda_gt_ref(16'(a), 16'(b)), "sweep");
          pairs_cnt++;
          if (P_in === 1'b1) ones_cnt++;
        end
      end
    end

    tests++;
    if (ones_cnt != 28) begin
      fails++;
      $display("FAIL sweep_ones: got %0d ones over %0d pairs, expected 28", ones_cnt, pairs_cnt);
    end

    // Back-to-back changes after the sweep: each result tracks its own operands.
    apply(3'b111, 3'b000, 1'b1, "b2b_gt");
    apply(3'b000, 3'b001, 1'b0, "b2b_lt");
    apply(3'b110, 3'b101, 1'b1, "b2b_gt2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
